// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-read-port register file.
//   rw_mode_e   : same-cycle same-address read behaviour
//   clr_state_e : clear sequencer state
//   bytes_of()  : number of byte lanes in a word
package reg_file_pkg;

    typedef enum {RW_WRITE_FIRST, RW_READ_FIRST} rw_mode_e;

    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_e;

    function automatic int unsigned bytes_of(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Clear sequencer: sweeps every address once after reset or on request.
//   i_clk      : clock
//   i_reset    : synchronous active-high reset, (re)starts the sweep at address 0
//   i_clear    : start a sweep, honoured only while idle
//   o_busy     : sweep in progress
//   o_clr_we   : write INIT value at o_clr_addr this cycle
//   o_clr_addr : current sweep address
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned LAST  = (1 << ADDR_WIDTH) - 1;

    clr_state_e       state_q, state_d;
    logic [CNT_W-1:0] addr_q, addr_d;
    logic             busy_d;

    // State, sweep counter and busy flag registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_CLEAR;
            addr_q  <= '0;
            o_busy  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            o_busy  <= busy_d;
        end
    end

    // Next state: one word per cycle, return to idle after the last address
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_clear) begin
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                end
            end
            ST_CLEAR: begin
                if (addr_q == CNT_W'(LAST)) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // The busy register doubles as the sweep write strobe
    assign o_clr_we   = o_busy;
    assign o_clr_addr = addr_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/reg_file_mp.sv
// Register file with one byte-enabled write port and NUM_RD_PORTS
// independent synchronous read ports, plus a built-in clear sweep.
//   i_clk     : clock
//   i_reset   : synchronous active-high reset
//   i_clear   : request a clear sweep (idle only)
//   i_wr_en   : write strobe; i_w_addr / i_w_data / i_w_be
//   i_rd_en   : per-port read strobe; i_r_addr packed per port
//   o_r_data  : packed per-port read data (latency 1, held when not strobed)
//   o_r_valid : per-port one-cycle pulse when o_r_data updates
//   o_busy    : clear sweep in progress
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter int unsigned           ADDR_WIDTH   = 4,
    parameter int unsigned           NUM_RD_PORTS = 2,
    parameter string                 RW_MODE      = "WRITE_FIRST",
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    parameter string                 MEMORY_TYPE  = "distributed"
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_clear,
    input  logic                                 i_wr_en,
    input  logic [ADDR_WIDTH-1:0]                i_w_addr,
    input  logic [DATA_WIDTH-1:0]                i_w_data,
    input  logic [bytes_of(DATA_WIDTH)-1:0]      i_w_be,
    input  logic [NUM_RD_PORTS-1:0]              i_rd_en,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   i_r_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   o_r_data,
    output logic [NUM_RD_PORTS-1:0]              o_r_valid,
    output logic                                 o_busy
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_BYTES = bytes_of(DATA_WIDTH);
    localparam rw_mode_e    RW_SEL    = (RW_MODE == "READ_FIRST") ? RW_READ_FIRST
                                                                  : RW_WRITE_FIRST;

    // Elaboration-time parameter checks
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
        $error("reg_file_mp: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (NUM_RD_PORTS < 1) begin : g_bad_ports
        $error("reg_file_mp: NUM_RD_PORTS must be at least 1");
    end
    if (RW_MODE != "WRITE_FIRST" && RW_MODE != "READ_FIRST") begin : g_bad_mode
        $error("reg_file_mp: RW_MODE must be WRITE_FIRST or READ_FIRST");
    end
    if (MEMORY_TYPE == "") begin : g_bad_memtype
        $error("reg_file_mp: MEMORY_TYPE must not be empty");
    end

    logic                  clr_busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  user_we;

    reg_file_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (i_clear),
        .o_busy     (clr_busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    assign o_busy = clr_busy;

    // User writes are dropped while sweeping or in reset
    assign user_we = i_wr_en & ~clr_busy & ~i_reset;

    (* ram_style = MEMORY_TYPE *)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Array write: sweep has priority over the user port
    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= INIT_VALUE;
        end else if (user_we) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (i_w_be[k]) begin
                    mem_q[i_w_addr][8*k +: 8] <= i_w_data[8*k +: 8];
                end
            end
        end
    end

    // Per-port read word, with byte-wise bypass of a same-address write
    logic [DATA_WIDTH-1:0] rd_word [NUM_RD_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_word[p] = mem_q[i_r_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
            if (RW_SEL == RW_WRITE_FIRST && user_we &&
                i_w_addr == i_r_addr[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (i_w_be[k]) begin
                        rd_word[p][8*k +: 8] = i_w_data[8*k +: 8];
                    end
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0]   r_data_q [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] r_valid_q;

    // Read registers: hold data when not strobed, ignore strobes while busy
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                r_data_q[p] <= '0;
            end
            r_valid_q <= '0;
        end else if (clr_busy) begin
            r_valid_q <= '0;
        end else begin
            r_valid_q <= i_rd_en;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (i_rd_en[p]) begin
                    r_data_q[p] <= rd_word[p];
                end
            end
        end
    end

    // Flatten per-port registers onto the packed output
    always_comb begin
        o_r_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            o_r_data[p*DATA_WIDTH +: DATA_WIDTH] = r_data_q[p];
        end
    end

    assign o_r_valid = r_valid_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: a WRITE_FIRST and a READ_FIRST
// instance share stimulus and are compared against one array-based model.
module tb_reg_file_mp;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NP    = 2;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] INIT = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, clear, wr_en;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_data;
    logic [1:0]       w_be;
    logic [NP-1:0]    rd_en;
    logic [NP*AW-1:0] r_addr;

    logic [NP*DW-1:0] rdata_wf, rdata_rf;
    logic [NP-1:0]    rvalid_wf, rvalid_rf;
    logic             busy_wf, busy_rf;

    reg_file_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NP),
        .RW_MODE("WRITE_FIRST"), .INIT_VALUE(INIT), .MEMORY_TYPE("distributed")
    ) dut_wf (
        .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_wr_en(wr_en),
        .i_w_addr(w_addr), .i_w_data(w_data), .i_w_be(w_be),
        .i_rd_en(rd_en), .i_r_addr(r_addr),
        .o_r_data(rdata_wf), .o_r_valid(rvalid_wf), .o_busy(busy_wf)
    );

    reg_file_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NP),
        .RW_MODE("READ_FIRST"), .INIT_VALUE(INIT), .MEMORY_TYPE("distributed")
    ) dut_rf (
        .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_wr_en(wr_en),
        .i_w_addr(w_addr), .i_w_data(w_data), .i_w_be(w_be),
        .i_rd_en(rd_en), .i_r_addr(r_addr),
        .o_r_data(rdata_rf), .o_r_valid(rvalid_rf), .o_busy(busy_rf)
    );

    // Reference model: plain array plus a count of remaining busy cycles
    logic [DW-1:0] m_mem [DEPTH];
    int            m_busy_left;
    int            m_sweep;
    logic [DW-1:0] m_rd_wf [NP];
    logic [DW-1:0] m_rd_rf [NP];
    logic [NP-1:0] m_valid;

    int total = 0;
    int bad   = 0;
    int n;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        logic [DW-1:0] merged;
        logic [AW-1:0] a;
        if (reset) begin
            m_busy_left = DEPTH;
            m_sweep     = 0;
            m_valid     = '0;
            for (int p = 0; p < NP; p++) begin
                m_rd_wf[p] = '0;
                m_rd_rf[p] = '0;
            end
        end else if (m_busy_left > 0) begin
            m_mem[m_sweep] = INIT;
            m_sweep++;
            m_busy_left--;
            m_valid = '0;
        end else begin
            merged = m_mem[w_addr];
            for (int k = 0; k < 2; k++)
                if (w_be[k]) merged[8*k +: 8] = w_data[8*k +: 8];
            for (int p = 0; p < NP; p++) begin
                if (rd_en[p]) begin
                    a = r_addr[p*AW +: AW];
                    m_rd_rf[p] = m_mem[a];
                    m_rd_wf[p] = (wr_en && a == w_addr) ? merged : m_mem[a];
                end
            end
            m_valid = rd_en;
            if (wr_en) m_mem[w_addr] = merged;
            if (clear) begin
                m_busy_left = DEPTH;
                m_sweep     = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("busy_wf",   busy_wf,   m_busy_left > 0);
        chk("busy_rf",   busy_rf,   m_busy_left > 0);
        chk("valid_wf",  rvalid_wf, m_valid);
        chk("valid_rf",  rvalid_rf, m_valid);
        chk("rdata_wf",  rdata_wf,  {m_rd_wf[1], m_rd_wf[0]});
        chk("rdata_rf",  rdata_rf,  {m_rd_rf[1], m_rd_rf[0]});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        clear  = 1'b0;
        wr_en  = 1'b0;
        w_addr = '0;
        w_data = '0;
        w_be   = '0;
        rd_en  = '0;
        r_addr = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        idle();
        wr_en = 1'b1; w_addr = a; w_data = d; w_be = be;
        step();
        idle();
    endtask

    task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        idle();
        rd_en = 2'b11; r_addr = {a1, a0};
        step();
        idle();
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (busy_wf && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = 'x;

        // Reset sweep: busy for exactly DEPTH cycles, then all words INIT
        step();
        reset = 1'b0;
        count_busy(n);
        chk("reset_sweep_len", n, 16);
        for (int a = 0; a < DEPTH; a++) begin
            rd2(AW'(a), AW'(DEPTH - 1 - a));
            chk("reset_rd_val", rdata_wf, 32'h0);
        end
        step();
        chk("valid_drops", rvalid_wf, 2'b00);

        // Byte-enable merge
        wr(4'd3, 16'hA1B2, 2'b11);
        wr(4'd3, 16'hFFCC, 2'b01);
        rd_en = 2'b01; r_addr = {4'd0, 4'd3};
        step();
        idle();
        chk("be_merge", rdata_wf[15:0], 16'hA1CC);

        // Read-during-write on both ports
        wr(4'd5, 16'h1111, 2'b11);
        wr_en = 1'b1; w_addr = 4'd5; w_data = 16'h2222; w_be = 2'b11;
        rd_en = 2'b11; r_addr = {4'd5, 4'd5};
        step();
        idle();
        chk("rdw_write_first", rdata_wf, 32'h2222_2222);
        chk("rdw_read_first",  rdata_rf, 32'h1111_1111);

        // Clear request with dropped writes and a mid-sweep re-request
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), 16'hBEEF, 2'b11);
        clear = 1'b1;
        step();
        clear = 1'b0;
        n = 0;
        while (busy_wf && n < 40) begin
            wr_en = 1'b1; w_addr = AW'(n); w_data = 16'h1234; w_be = 2'b11;
            clear = (n == 5);
            step();
            n++;
        end
        idle();
        chk("clear_sweep_len", n, 16);
        for (int a = 0; a < DEPTH; a++) begin
            rd2(AW'(a), AW'(a));
            chk("clear_rd_val", rdata_wf, 32'h0);
        end

        // Reset at sweep cycle 7 restarts the full sweep
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), 16'h5A5A ^ DW'(a), 2'b11);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy(n);
        chk("reset_mid_len", n, 16);

        // Independent ports
        wr(4'd9, 16'h9C9C, 2'b11);
        wr(4'd2, 16'h0202, 2'b11);
        rd_en = 2'b10; r_addr = {4'd9, 4'd0};
        step();
        rd_en = 2'b01; r_addr = {4'd7, 4'd2};
        step();
        idle();
        chk("indep_valid", rvalid_wf, 2'b01);
        chk("indep_hold",  rdata_wf,  32'h9C9C_0202);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            clear  = ($urandom_range(0, 59) == 0);
            wr_en  = $urandom_range(0, 1);
            w_addr = AW'($urandom);
            w_data = DW'($urandom);
            w_be   = 2'($urandom);
            rd_en  = NP'($urandom);
            r_addr = (NP*AW)'($urandom);
            if ($urandom_range(0, 2) == 0) r_addr[AW-1:0] = w_addr;
            if ($urandom_range(0, 2) == 0) r_addr[2*AW-1:AW] = w_addr;
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
